// File: rtl/bmp_pkg.sv
// Shared constants for the BMP pixel processing stage.
// State encoding, header signature and pixel operation selects.
package bmp_pkg;

    localparam int HDR_BYTES_C = 54;

    localparam logic [7:0] BMP_SIG_B = 8'h42;
    localparam logic [7:0] BMP_SIG_M = 8'h4D;

    localparam logic MODE_THRESH = 1'b0;
    localparam logic MODE_BRIGHT = 1'b1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] HEADER = 2'd1;
    localparam logic [1:0] PIXELS = 2'd2;

endpackage

// File: rtl/bmp_byte_op.sv
// Per-byte pixel operation: threshold or saturating brightness.
// Passes the byte through unchanged when en is low.
module bmp_byte_op
    import bmp_pkg::*;
(
    input  logic       mode,
    input  logic [7:0] p,
    input  logic       en,
    input  logic [7:0] b,
    output logic [7:0] y
);

    logic [8:0] sum;
    logic [7:0] res;

    always_comb begin
        sum = {1'b0, b} + {1'b0, p};
        if (mode == MODE_BRIGHT)
            res = sum[8] ? 8'hFF : sum[7:0];
        else
            res = (b >= p) ? 8'hFF : 8'h00;
        y = en ? res : b;
    end

endmodule

// File: rtl/bmp_pixel_proc.sv
// BMP header parser and per-byte pixel processor with registered output.
// Optional PIX_STATS_EN adds the pix_cnt processed-byte counter port.
module bmp_pixel_proc
    import bmp_pkg::*;
#(
    parameter int DATA_BUS_SIZE = 32,
    parameter int HDR_BYTES     = HDR_BYTES_C
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_BUS_SIZE-1:0] in_data,
    input  logic                     in_mode,
    input  logic [7:0]               in_data_proc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_BUS_SIZE-1:0] out_data,
    output logic                     out_last,
    output logic [31:0]              file_size,
    output logic                     hdr_err
`ifdef PIX_STATS_EN
    ,
    output logic [31:0]              pix_cnt
`endif
);

    localparam int          BPW   = DATA_BUS_SIZE / 8;
    localparam logic [31:0] BPW_W = 32'(BPW);
    localparam logic [31:0] HDR_W = 32'(HDR_BYTES);

    logic [1:0]               state, state_nxt;
    logic [31:0]              byte_cnt, fs_nxt;
    logic                     mode_q, mode_eff;
    logic [7:0]               p_q, p_eff, sig0_q, sig0_nxt;
    logic                     accept, first, sig_bad, hdr_end;
    logic                     err_nxt, err_fin, is_last;
    logic [BPW-1:0]           en;
    logic [DATA_BUS_SIZE-1:0] proc_data;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign first    = (state == IDLE);

    // Header capture: byte_cnt is 0 in IDLE, so offsets are absolute.
    always_comb begin : scan
        logic [31:0] off;
        logic [7:0]  bk;
        fs_nxt   = file_size;
        sig0_nxt = sig0_q;
        sig_bad  = 1'b0;
        hdr_end  = 1'b0;
        for (int k = 0; k < BPW; k++) begin
            off = byte_cnt + 32'(k);
            bk  = in_data[8*k +: 8];
            if (off == 32'd0)
                sig0_nxt = bk;
            if (off == 32'd1)
                sig_bad = (sig0_nxt != BMP_SIG_B) || (bk != BMP_SIG_M);
            case (off)
                32'd2:   fs_nxt[7:0]   = bk;
                32'd3:   fs_nxt[15:8]  = bk;
                32'd4:   fs_nxt[23:16] = bk;
                32'd5:   fs_nxt[31:24] = bk;
                default: ;
            endcase
            if (off == HDR_W - 32'd1)
                hdr_end = 1'b1;
        end
        err_nxt = (first ? 1'b0 : hdr_err) | sig_bad;
        err_fin = err_nxt | (hdr_end && (fs_nxt <= HDR_W));
    end

    always_comb begin : mask
        logic [31:0] off;
        en = '0;
        for (int k = 0; k < BPW; k++) begin
            off   = byte_cnt + 32'(k);
            en[k] = !err_fin && (off >= HDR_W) && (off < fs_nxt);
        end
    end

    always_comb begin
        if (hdr_end)
            is_last = err_fin || (fs_nxt <= byte_cnt + BPW_W);
        else
            is_last = (state == PIXELS) && (byte_cnt + BPW_W >= fs_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            unique case (1'b1)
                is_last:
                    state_nxt = IDLE;
                !is_last && (hdr_end || state == PIXELS):
                    state_nxt = PIXELS;
                default:
                    state_nxt = HEADER;
            endcase
        end
    end

    // The first beat uses the live operands; later beats use latched ones.
    always_comb begin
        mode_eff = first ? in_mode : mode_q;
        p_eff    = first ? in_data_proc : p_q;
    end

    for (genvar g = 0; g < BPW; g++) begin : g_op
        bmp_byte_op u_op (
            .mode (mode_eff),
            .p    (p_eff),
            .en   (en[g]),
            .b    (in_data[8*g +: 8]),
            .y    (proc_data[8*g +: 8])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt  <= '0;
            file_size <= '0;
            hdr_err   <= 1'b0;
            sig0_q    <= '0;
            mode_q    <= MODE_THRESH;
            p_q       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (accept) begin
                byte_cnt  <= (state_nxt == IDLE) ? 32'd0 : byte_cnt + BPW_W;
                file_size <= fs_nxt;
                sig0_q    <= sig0_nxt;
                hdr_err   <= err_fin;
                if (first) begin
                    mode_q <= in_mode;
                    p_q    <= in_data_proc;
                end
                out_valid <= 1'b1;
                out_data  <= proc_data;
                out_last  <= is_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef PIX_STATS_EN
    logic [31:0] n_proc;

    always_comb begin
        n_proc = '0;
        for (int k = 0; k < BPW; k++)
            n_proc = n_proc + 32'(en[k]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pix_cnt <= '0;
        else if (accept)
            pix_cnt <= (first ? 32'd0 : pix_cnt) + n_proc;
    end
`endif

endmodule

// File: doc/bmp_pixel_proc.md
Name: bmp_pixel_proc

Overview:
Downstream stage of the BMP arbiter, consuming its processor-side word stream together with the per-image mode and processing byte.
- Parses the 54-byte BMP header on the fly, checks the signature and extracts the file size.
- Passes header bytes through untouched.
- Applies a per-byte pixel operation (threshold or saturating brightness) to every byte from offset 54 to end-of-file.
- Emits a registered valid/ready stream with an end-of-image marker toward the master side.

Parameters:
DATA_BUS_SIZE, 32, bus width in bits; legal values 32 or 64; BPW = DATA_BUS_SIZE/8 bytes per word.
HDR_BYTES, 54, header length in bytes; all bytes below this offset are never modified.

Ports:
clk  in  1  clock, all logic on rising edge.
rst_n  in  1  reset, asynchronous, active-low.
in_valid  in  1  input word valid.
in_ready  out  1  block can accept a word this cycle.
in_data  in  DATA_BUS_SIZE  input word, little-endian: byte k = in_data[8k+7:8k].
in_mode  in  1  operation select, 0 = threshold, 1 = brightness; sampled on first beat of an image.
in_data_proc  in  8  operation operand; sampled on first beat.
out_valid  out  1  output word valid.
out_ready  in  1  downstream accepts the word.
out_data  out  DATA_BUS_SIZE  processed word.
out_last  out  1  qualifies the final word of the image.
file_size  out  32  file size from header bytes 2..5; valid once the word containing byte 5 is accepted.
hdr_err  out  1  sticky header error for the current image; cleared on the next image's first beat.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_last=0, file_size=0, hdr_err=0, state=IDLE, byte counter=0. in_ready=1 once reset is released.
- Handshake:
  - An input transfer occurs when in_valid && in_ready.
  - in_ready = !out_valid || out_ready (single output register, no combinational in_data->out_data path).
  - Latency is 1 cycle from input accept to out_valid.
  - out_data and out_last hold stable while out_valid && !out_ready.
- Counter: byte_cnt (32 bit) is the offset of byte 0 of the current word; it adds BPW per accepted word.
- Per-byte offset: byte k of a word has offset byte_cnt+k.
  - Offset < HDR_BYTES: byte passes unchanged.
  - HDR_BYTES <= offset < file_size: byte is processed.
  - Offset >= file_size (tail padding): byte passes unchanged.
- Pixel operations (per byte b, operand p latched at image start):
  - threshold: out = (b >= p) ? 8'hFF : 8'h00.
  - brightness: out = min(b + p, 255), using a 9-bit sum.
- State machine:
  - IDLE: the first accepted word latches mode and p, clears hdr_err, then enters HEADER.
  - HEADER: captures bytes 0..5 as they arrive. Signature is checked when byte 1 is seen: byte0 must be 8'h42 and byte1 must be 8'h4D, otherwise hdr_err=1. file_size is assembled from bytes 2..5 (byte 5 = MSB). On accepting the word containing offset HDR_BYTES-1:
    - if hdr_err, or file_size <= HDR_BYTES: set hdr_err, mark that word out_last, go to IDLE.
    - else go to PIXELS.
  - PIXELS: processes bytes per the offset rules. The word with byte_cnt+BPW >= file_size is marked out_last, then go to IDLE with byte_cnt=0.
- Header straddle: with BPW=4, word 13 holds bytes 52..55. Bytes 52 and 53 pass unchanged; bytes 54 and 55 are processed. The per-byte mask handles this for any BPW.
- An error image terminates after the header word; following words start a new image (the signature check fails again until a valid header arrives).
- Back-to-back images are allowed: the word after out_last's input word may be accepted in the same cycle the state returns to IDLE, with no bubble.
- Reset mid-image: everything returns to reset values immediately; partial output is discarded.

Optional Feature:
PIX_STATS_EN
- Defined: adds output port pix_cnt (32 bit) = number of pixel bytes processed in the current or most recent image. It is cleared on an image's first beat, increments by the count of processed bytes per accepted word, and resets to 0.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package bmp_pkg holds:
  - HDR_BYTES_C = 54.
  - BMP_SIG_B = 8'h42, BMP_SIG_M = 8'h4D.
  - MODE_THRESH = 1'b0, MODE_BRIGHT = 1'b1.
  - State encoding IDLE/HEADER/PIXELS as 2-bit localparams.
- Sub-module bmp_byte_op: combinational 8-bit op (mode, p, enable) -> byte, instantiated BPW times via generate.

Test Plan:
1. Threshold, p=8'h80, valid header with file_size=62, 32-bit bus: 16 beats in. Pixel 8'h7F->8'h00, 8'h80->8'hFF. Word 13 bytes 52/53 unchanged, 54/55 processed. out_last on beat 16 only; file_size=62; bytes 62/63 unchanged.
2. Brightness, p=8'h20: pixels 8'hF0->8'hFF (saturate), 8'h10->8'h30, 8'hDF->8'hFF. Header words bit-identical to input.
3. Backpressure: out_ready toggles 1,0,0,1 during PIXELS. in_ready low whenever out_valid && !out_ready; no word lost or duplicated; out_data stable while stalled.
4. Bad signature (byte0=8'h41): hdr_err=1, no byte modified, out_last on beat 14. The next valid image clears hdr_err on its first beat.
5. Reset mid-image: assert rst_n=0 at beat 20 of a file_size=200 image. Outputs zero immediately; a fresh image after release processes correctly from offset 0.
6. Back-to-back two images (file_size=58 then 60) with in_valid held high: no idle cycle between them, and each image's mode/p is latched independently.
